// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared definitions for the ID/EX stage: ALU op width, control-word layout and bubble value.
package id_ex_pipe_reg_pkg;

   localparam int ALU_OP_W = 3;

   // Control word, MSB first: reg_dst .. mem_write
   typedef struct packed {
      logic reg_dst;
      logic jal_reg;
      logic pc_to_reg;
      logic alu_src;
      logic mem_to_reg;
      logic reg_write;
      logic mem_read;
      logic mem_write;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = ctrl_t'(8'b0);

endpackage

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// Load-use hazard check: a valid load in EX whose destination feeds the ID instruction.
module load_use_detect #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  ex_valid_i,
   input  logic                  ex_mem_read_i,
   input  logic [REG_ADDR_W-1:0] ex_rt_i,
   input  logic [REG_ADDR_W-1:0] id_rs_i,
   input  logic [REG_ADDR_W-1:0] id_rt_i,
   output logic                  hazard_o
);

   logic rt_nonzero;
   logic rt_match;

   // $0 is hard-wired, so a load targeting it can never feed a consumer
   assign rt_nonzero = (ex_rt_i != '0);
   assign rt_match   = (ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i);
   assign hazard_o   = ex_valid_i & ex_mem_read_i & rt_nonzero & rt_match;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use stall/bubble insertion and a saturating stall counter.
module id_ex_pipe_reg
   import id_ex_pipe_reg_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int ALU_OP_W_P = ALU_OP_W,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_reg_dst,
   input  logic                  id_jal_reg,
   input  logic                  id_pc_to_reg,
   input  logic                  id_alu_src,
   input  logic                  id_mem_to_reg,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  id_mem_write,
   input  logic [ALU_OP_W_P-1:0] id_alu_operation,
   input  logic [DATA_W-1:0]     id_rd1,
   input  logic [DATA_W-1:0]     id_rd2,
   input  logic [DATA_W-1:0]     id_imm,
   input  logic [DATA_W-1:0]     id_pc_plus4,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_flush,
   output logic                  ex_reg_dst,
   output logic                  ex_jal_reg,
   output logic                  ex_pc_to_reg,
   output logic                  ex_alu_src,
   output logic                  ex_mem_to_reg,
   output logic                  ex_reg_write,
   output logic                  ex_mem_read,
   output logic                  ex_mem_write,
   output logic [ALU_OP_W_P-1:0] ex_alu_operation,
   output logic [DATA_W-1:0]     ex_rd1,
   output logic [DATA_W-1:0]     ex_rd2,
   output logic [DATA_W-1:0]     ex_imm,
   output logic [DATA_W-1:0]     ex_pc_plus4,
   output logic [REG_ADDR_W-1:0] ex_rs,
   output logic [REG_ADDR_W-1:0] ex_rt,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  ex_valid,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic [CNT_W-1:0]      stall_count
);

   ctrl_t                  id_ctrl;
   ctrl_t                  ctrl_d, ctrl_q;
   logic                   valid_d, valid_q;
   logic [ALU_OP_W_P-1:0]  alu_op_q;
   logic [DATA_W-1:0]      rd1_q, rd2_q, imm_q, pc_plus4_q;
   logic [REG_ADDR_W-1:0]  rs_q, rt_q, rd_q;
   logic [CNT_W-1:0]       cnt_d, cnt_q;
   logic                   hazard;
   logic                   bubble;

   assign id_ctrl = ctrl_t'({id_reg_dst, id_jal_reg, id_pc_to_reg, id_alu_src,
                             id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write});

   load_use_detect #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_load_use_detect (
      .ex_valid_i    (valid_q),
      .ex_mem_read_i (ctrl_q.mem_read),
      .ex_rt_i       (rt_q),
      .id_rs_i       (id_rs),
      .id_rt_i       (id_rt),
      .hazard_o      (hazard)
   );

   // Stall handshake ignores flush: a squashed ID slot still waits out the load
   assign pc_write    = ~hazard;
   assign if_id_write = ~hazard;
   assign bubble      = hazard | id_flush;

   always_comb begin
      ctrl_d  = id_ctrl;
      valid_d = 1'b1;
      cnt_d   = cnt_q;
      if (bubble) begin
         ctrl_d  = CTRL_NOP;
         valid_d = 1'b0;
      end
      if (hazard && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_q     <= CTRL_NOP;
         valid_q    <= 1'b0;
         alu_op_q   <= '0;
         rd1_q      <= '0;
         rd2_q      <= '0;
         imm_q      <= '0;
         pc_plus4_q <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
      end else begin
         ctrl_q     <= ctrl_d;
         valid_q    <= valid_d;
         alu_op_q   <= id_alu_operation;
         rd1_q      <= id_rd1;
         rd2_q      <= id_rd2;
         imm_q      <= id_imm;
         pc_plus4_q <= id_pc_plus4;
         rs_q       <= id_rs;
         rt_q       <= id_rt;
         rd_q       <= id_rd;
         cnt_q      <= cnt_d;
      end
   end

   assign ex_reg_dst       = ctrl_q.reg_dst;
   assign ex_jal_reg       = ctrl_q.jal_reg;
   assign ex_pc_to_reg     = ctrl_q.pc_to_reg;
   assign ex_alu_src       = ctrl_q.alu_src;
   assign ex_mem_to_reg    = ctrl_q.mem_to_reg;
   assign ex_reg_write     = ctrl_q.reg_write;
   assign ex_mem_read      = ctrl_q.mem_read;
   assign ex_mem_write     = ctrl_q.mem_write;
   assign ex_alu_operation = alu_op_q;
   assign ex_rd1           = rd1_q;
   assign ex_rd2           = rd2_q;
   assign ex_imm           = imm_q;
   assign ex_pc_plus4      = pc_plus4_q;
   assign ex_rs            = rs_q;
   assign ex_rt            = rt_q;
   assign ex_rd            = rd_q;
   assign ex_valid         = valid_q;
   assign stall_count      = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: scoreboard queue of expected EX contents, CNT_W=4.
module tb_id_ex_pipe_reg;

   localparam int CNT_W = 4;
   localparam logic [7:0] C_ADD = 8'b1000_0100;
   localparam logic [7:0] C_LW  = 8'b0001_1110;
   localparam logic [7:0] C_SW  = 8'b0001_0001;

   typedef struct {
      logic [7:0]  ctrl;
      logic [2:0]  aop;
      logic [31:0] rd1, rd2, imm, pc4;
      logic [4:0]  rs, rt, rd;
      logic        flush;
   } id_t;

   typedef struct {
      logic [7:0]       ctrl;
      logic [2:0]       aop;
      logic [31:0]      rd1, rd2, imm, pc4;
      logic [4:0]       rs, rt, rd;
      logic             valid;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic id_reg_dst, id_jal_reg, id_pc_to_reg, id_alu_src;
   logic id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write;
   logic [2:0]  id_alu_operation;
   logic [31:0] id_rd1, id_rd2, id_imm, id_pc_plus4;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        id_flush;
   logic ex_reg_dst, ex_jal_reg, ex_pc_to_reg, ex_alu_src;
   logic ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write;
   logic [2:0]  ex_alu_operation;
   logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc_plus4;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic        ex_valid, pc_write, if_id_write;
   logic [CNT_W-1:0] stall_count;
   logic [7:0]  ex_ctrl;

   int total = 0;
   int fails = 0;
   logic [CNT_W-1:0] mcnt = '0;
   exp_t sb[$];

   always #5 clk = ~clk;

   assign ex_ctrl = {ex_reg_dst, ex_jal_reg, ex_pc_to_reg, ex_alu_src,
                     ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write};

   id_ex_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .ALU_OP_W_P(3), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_reg_dst(id_reg_dst), .id_jal_reg(id_jal_reg), .id_pc_to_reg(id_pc_to_reg),
      .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_alu_operation(id_alu_operation), .id_rd1(id_rd1), .id_rd2(id_rd2),
      .id_imm(id_imm), .id_pc_plus4(id_pc_plus4), .id_rs(id_rs), .id_rt(id_rt),
      .id_rd(id_rd), .id_flush(id_flush),
      .ex_reg_dst(ex_reg_dst), .ex_jal_reg(ex_jal_reg), .ex_pc_to_reg(ex_pc_to_reg),
      .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_alu_operation(ex_alu_operation), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
      .ex_imm(ex_imm), .ex_pc_plus4(ex_pc_plus4), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_rd(ex_rd), .ex_valid(ex_valid), .pc_write(pc_write),
      .if_id_write(if_id_write), .stall_count(stall_count)
   );

   function automatic id_t mk(input logic [7:0] ctrl, input logic [2:0] aop,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic flush);
      id_t x;
      x.ctrl = ctrl; x.aop = aop; x.rs = rs; x.rt = rt; x.rd = rd;
      x.rd1 = rd1; x.rd2 = rd2; x.flush = flush;
      x.imm = {16'h0, 11'h0, rs} ^ 32'h0000_1230;
      x.pc4 = {16'h0040, 8'h00, 3'b000, rd} << 2;
      return x;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply(input id_t x);
      {id_reg_dst, id_jal_reg, id_pc_to_reg, id_alu_src,
       id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write} = x.ctrl;
      id_alu_operation = x.aop;
      id_rd1 = x.rd1; id_rd2 = x.rd2; id_imm = x.imm; id_pc_plus4 = x.pc4;
      id_rs = x.rs; id_rt = x.rt; id_rd = x.rd; id_flush = x.flush;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ctrl"}, {24'h0, ex_ctrl}, 32'h0);
      chk({tag, "_valid"}, {31'h0, ex_valid}, 32'h0);
      chk({tag, "_rd1"}, ex_rd1, 32'h0);
      chk({tag, "_rt"}, {27'h0, ex_rt}, 32'h0);
      chk({tag, "_cnt"}, {28'h0, stall_count}, 32'h0);
      chk({tag, "_pcw"}, {31'h0, pc_write}, 32'h1);
      chk({tag, "_ifidw"}, {31'h0, if_id_write}, 32'h1);
   endtask

   // Drive one ID instruction, check the stall handshake, then compare EX after the edge
   task automatic step(input string tag, input id_t x, input logic exp_haz);
      exp_t e;
      @(negedge clk);
      apply(x);
      #1;
      chk({tag, "_pcw"}, {31'h0, pc_write}, {31'h0, ~exp_haz});
      chk({tag, "_ifidw"}, {31'h0, if_id_write}, {31'h0, ~exp_haz});
      e.ctrl = (exp_haz || x.flush) ? 8'h00 : x.ctrl;
      e.valid = !(exp_haz || x.flush);
      e.aop = x.aop; e.rd1 = x.rd1; e.rd2 = x.rd2; e.imm = x.imm; e.pc4 = x.pc4;
      e.rs = x.rs; e.rt = x.rt; e.rd = x.rd;
      if (exp_haz && mcnt != 4'hF) mcnt = mcnt + 4'h1;
      e.cnt = mcnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'h0, 32'h1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_ctrl"}, {24'h0, ex_ctrl}, {24'h0, e.ctrl});
         chk({tag, "_valid"}, {31'h0, ex_valid}, {31'h0, e.valid});
         chk({tag, "_aop"}, {29'h0, ex_alu_operation}, {29'h0, e.aop});
         chk({tag, "_rd1"}, ex_rd1, e.rd1);
         chk({tag, "_rd2"}, ex_rd2, e.rd2);
         chk({tag, "_imm"}, ex_imm, e.imm);
         chk({tag, "_pc4"}, ex_pc_plus4, e.pc4);
         chk({tag, "_regs"}, {17'h0, ex_rs, ex_rt, ex_rd}, {17'h0, e.rs, e.rt, e.rd});
         chk({tag, "_cnt"}, {28'h0, stall_count}, {28'h0, e.cnt});
      end
   endtask

   initial begin
      apply(mk(C_LW, 3'd2, 5'd3, 5'd8, 5'd0, 32'hDEAD, 32'hBEEF, 1'b0));
      #1;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      step("add_pass", mk(C_ADD, 3'd2, 5'd9, 5'd10, 5'd8, 32'd5, 32'd7, 1'b0), 1'b0);
      step("lw8", mk(C_LW, 3'd2, 5'd9, 5'd8, 5'd0, 32'd100, 32'd0, 1'b0), 1'b0);
      step("use_rs", mk(C_ADD, 3'd2, 5'd8, 5'd10, 5'd11, 32'd1, 32'd2, 1'b0), 1'b1);
      step("use_adv", mk(C_ADD, 3'd2, 5'd8, 5'd10, 5'd11, 32'd1, 32'd2, 1'b0), 1'b0);
      step("lw_r0", mk(C_LW, 3'd2, 5'd1, 5'd0, 5'd0, 32'd4, 32'd0, 1'b0), 1'b0);
      step("read_r0", mk(C_ADD, 3'd2, 5'd0, 5'd0, 5'd12, 32'd0, 32'd0, 1'b0), 1'b0);
      step("sw8", mk(C_SW, 3'd2, 5'd2, 5'd8, 5'd0, 32'd8, 32'd9, 1'b0), 1'b0);
      step("after_sw", mk(C_ADD, 3'd6, 5'd8, 5'd3, 5'd13, 32'd3, 32'd4, 1'b0), 1'b0);
      step("flush_sw", mk(C_SW, 3'd2, 5'd4, 5'd5, 5'd0, 32'd11, 32'd12, 1'b1), 1'b0);
      step("lw8b", mk(C_LW, 3'd2, 5'd9, 5'd8, 5'd0, 32'd20, 32'd0, 1'b0), 1'b0);
      step("flush_haz", mk(C_SW, 3'd2, 5'd3, 5'd8, 5'd0, 32'd21, 32'd22, 1'b1), 1'b1);
      step("lw5", mk(C_LW, 3'd2, 5'd9, 5'd5, 5'd0, 32'd30, 32'd0, 1'b0), 1'b0);
      step("use_rt", mk(C_ADD, 3'd1, 5'd1, 5'd5, 5'd14, 32'd31, 32'd32, 1'b0), 1'b1);
      step("use_rt_adv", mk(C_ADD, 3'd1, 5'd1, 5'd5, 5'd14, 32'd31, 32'd32, 1'b0), 1'b0);

      // Reset asserted while a load-use stall is pending
      step("lw_pre_rst", mk(C_LW, 3'd2, 5'd9, 5'd8, 5'd0, 32'd40, 32'd0, 1'b0), 1'b0);
      @(negedge clk);
      apply(mk(C_ADD, 3'd2, 5'd8, 5'd10, 5'd15, 32'd41, 32'd42, 1'b0));
      #1;
      chk("mid_stall_pcw", {31'h0, pc_write}, 32'h0);
      rst = 1'b0;
      #1;
      check_zero("rst_mid");
      mcnt = '0;
      @(posedge clk);
      #1;
      check_zero("rst_held");
      @(negedge clk);
      rst = 1'b1;
      step("post_rst", mk(C_ADD, 3'd2, 5'd8, 5'd10, 5'd15, 32'd41, 32'd42, 1'b0), 1'b0);

      for (int i = 0; i < 20; i++) begin
         step("sat_lw", mk(C_LW, 3'd2, 5'd9, 5'd8, 5'd0, 32'(i), 32'd0, 1'b0), 1'b0);
         step("sat_use", mk(C_ADD, 3'd2, 5'd8, 5'd1, 5'd2, 32'(i), 32'd1, 1'b0), 1'b1);
      end
      chk("sat_final", {28'h0, stall_count}, 32'd15);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
